gray_step_scheduler: RTL and testbench

- Round-robin scheduler that shares one 3-bit gray-code step counter among NREQ requesters.
- Each requester asks for a burst of Len counter steps. The scheduler grants one requester at a time and drives the counter's enable for exactly that many unheld cycles, then reports completion.
- Sits between the requesting blocks and the counter's En input. The counter's Output/Overflow go straight to the consumers, untouched by this block.

---
 rtl/gray_step_scheduler.sv | 134 +++++++++++++
 tb/tb_gray_step_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_scheduler.sv
// Round-robin owner of a shared gray-code step counter.
// Grants one requester a burst of Len unheld enable cycles, then pulses Done.
module gray_step_scheduler #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int ID_W  = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*LEN_W-1:0] Len,
    input  logic                  Hold,
    output logic [NREQ-1:0]       Grant,
    output logic                  Busy,
    output logic                  Cnt_En,
    output logic [LEN_W-1:0]      Steps_Left,
    output logic                  Done,
    output logic [ID_W-1:0]       Done_Id
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     start;
    logic [ID_W-1:0]     win;
    logic [ID_W:0]       sum;
    logic [2*NREQ-1:0]   dbl;
    logic [2*NREQ-1:0]   sh;
    logic [NREQ-1:0]     rot;
    logic [NREQ-1:0]     win_oh;
    logic [LEN_W-1:0]    win_len;
    logic                hit;

    // Rotate requests so bit 0 is the requester just after the last winner.
    always_comb begin
        start   = (ptr == ID_W'(NREQ - 1)) ? '0 : ptr + 1'b1;
        dbl     = {Req, Req};
        sh      = dbl >> start;
        rot     = sh[NREQ-1:0];
        hit     = |rot;
        sum     = '0;
        win     = '0;
        win_oh  = '0;
        win_len = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = {1'b0, start} + (ID_W + 1)'(j);
            end
        end
        if (sum >= (ID_W + 1)'(NREQ)) begin
            sum = sum - (ID_W + 1)'(NREQ);
        end
        win = sum[ID_W-1:0];
        for (int i = 0; i < NREQ; i++) begin
            if (win == ID_W'(i)) begin
                win_oh[i] = 1'b1;
                win_len   = Len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_nx = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!Hold && Steps_Left == LEN_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Cnt_En = (state == RUN) && !Hold;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ptr        <= ID_W'(NREQ - 1);
            Grant      <= '0;
            Busy       <= 1'b0;
            Steps_Left <= '0;
            Done       <= 1'b0;
            Done_Id    <= '0;
        end else begin
            state <= state_nx;
            Busy  <= (state_nx != IDLE);
            Done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        ptr        <= win;
                        Grant      <= win_oh;
                        Steps_Left <= win_len;
                        if (win_len == '0) begin
                            Done    <= 1'b1;
                            Done_Id <= win;
                        end
                    end
                end
                RUN: begin
                    if (!Hold) begin
                        Steps_Left <= Steps_Left - 1'b1;
                        if (Steps_Left == LEN_W'(1)) begin
                            Done    <= 1'b1;
                            Done_Id <= ptr;
                        end
                    end
                end
                DONE: begin
                    Grant      <= '0;
                    Steps_Left <= '0;
                end
                default: begin
                    Grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_step_scheduler.sv
// Randomized check of gray_step_scheduler against a burst-level model.
// Directed bursts from the plan are followed by a long random run.
module tb_gray_step_scheduler;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int ID_W  = 2;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic [NREQ-1:0]       Req;
    logic [NREQ*LEN_W-1:0] Len;
    logic                  Hold;
    logic [NREQ-1:0]       Grant;
    logic                  Busy;
    logic                  Cnt_En;
    logic [LEN_W-1:0]      Steps_Left;
    logic                  Done;
    logic [ID_W-1:0]       Done_Id;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner (-1 none), unheld steps remaining, done phase flag.
    int m_owner;
    int m_left;
    int m_done;
    int m_ptr;
    int m_done_id;

    gray_step_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Len(Len), .Hold(Hold),
        .Grant(Grant), .Busy(Busy), .Cnt_En(Cnt_En),
        .Steps_Left(Steps_Left), .Done(Done), .Done_Id(Done_Id)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int i);
        return int'(Len[i*LEN_W +: LEN_W]);
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_left    = 0;
        m_done    = 0;
        m_ptr     = NREQ - 1;
        m_done_id = 0;
    endtask

    task automatic model_edge();
        if (m_owner < 0) begin
            if (Req != '0) begin
                for (int o = 1; o <= NREQ; o++) begin
                    int i;
                    i = (m_ptr + o) % NREQ;
                    if (m_owner < 0 && Req[i]) m_owner = i;
                end
                m_ptr  = m_owner;
                m_left = len_of(m_owner);
                if (m_left == 0) begin
                    m_done    = 1;
                    m_done_id = m_owner;
                end
            end
        end else if (m_done != 0) begin
            m_owner = -1;
            m_done  = 0;
        end else if (!Hold) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done    = 1;
                m_done_id = m_owner;
            end
        end
    endtask

    task automatic check_outputs();
        int eg;
        int ee;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        ee = (m_owner >= 0 && m_done == 0 && !Hold) ? 1 : 0;
        chk("grant", int'(Grant), eg);
        chk("busy", int'(Busy), (m_owner >= 0) ? 1 : 0);
        chk("cnt_en", int'(Cnt_En), ee);
        chk("steps_left", int'(Steps_Left), m_left);
        chk("done", int'(Done), m_done);
        chk("done_id", int'(Done_Id), m_done_id);
        chk("grant_onehot0", int'($onehot0(Grant)), 1);
        chk("done_vs_en", int'(Done && Cnt_En), 0);
    endtask

    // Inputs are driven at the falling edge before each call.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge Clk);
        if (Reset) model_edge();
        @(negedge Clk);
    endtask

    task automatic pulse_reset();
        Reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic set_len(input int i, input int v);
        Len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    initial begin
        int en_cnt;
        Reset = 1'b0;
        Req   = '0;
        Len   = '0;
        Hold  = 1'b0;
        model_reset();
        @(negedge Clk);
        #1;
        check_outputs();
        @(negedge Clk);
        Reset = 1'b1;

        // single grant, Len0=3
        Req = 4'b0001;
        set_len(0, 3);
        cyc();
        Req = '0;
        for (int k = 0; k < 5; k++) cyc();

        // fairness with all Len=1
        Req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        for (int k = 0; k < 15; k++) cyc();
        Req = '0;
        for (int k = 0; k < 3; k++) cyc();

        // zero-length burst
        Req = 4'b0100;
        set_len(2, 0);
        cyc();
        Req = '0;
        for (int k = 0; k < 3; k++) cyc();

        // hold mid-burst, Len1=4
        Req = 4'b0010;
        set_len(1, 4);
        cyc();
        Req = '0;
        en_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            Hold = (k == 2 || k == 3);
            #1;
            en_cnt += int'(Cnt_En);
            #0;
            cyc();
        end
        Hold = 1'b0;
        chk("hold_en_total", en_cnt, 4);
        cyc();

        // reset mid-run, then pointer restored
        Req = 4'b0001;
        set_len(0, 7);
        cyc();
        Req = '0;
        cyc();
        cyc();
        chk("pre_rst_steps", int'(Steps_Left), 5);
        pulse_reset();
        Req = 4'b1010;
        cyc();
        chk("rr_after_rst", int'(Grant), 2);
        Req = '0;
        for (int k = 0; k < 12; k++) cyc();

        // withdrawal during run
        Req = 4'b1001;
        set_len(0, 2);
        set_len(3, 1);
        pulse_reset();
        cyc();
        Req = 4'b1000;
        for (int k = 0; k < 8; k++) cyc();
        Req = '0;
        for (int k = 0; k < 3; k++) cyc();

        // random run
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) Req = NREQ'($urandom);
            if ($urandom_range(0, 7) == 0) Len = (NREQ * LEN_W)'($urandom);
            Hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
